// File: rtl/tkip_sbox_pkg.sv
// -----------------------------------------------------------------------------
// tkip_sbox_pkg
// Shared definitions for the TKIP S-box lookup server:
//   - NUM_CH_MAX   : largest supported number of requesting channels
//   - tkipMode_e   : per-request output format encodings
//   - xtime        : GF(2^8) multiply-by-2 with the AES polynomial
//   - tkipFormat   : builds the 16-bit result word from an S-box byte
// -----------------------------------------------------------------------------
package tkip_sbox_pkg;

    localparam int NUM_CH_MAX = 8;

    typedef enum logic [1:0] {
        TKIP_MODE_STD  = 2'b00,  // {k2,k3}
        TKIP_MODE_SWAP = 2'b01,  // {k3,k2}
        TKIP_MODE_AES  = 2'b10   // {8'h00,S}
    } tkipMode_e;

    // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Result word for one lookup; the unused code 2'b11 falls back to the
    // standard TKIP word.
    function automatic logic [15:0] tkipFormat(input logic [7:0] s, input logic [1:0] mode);
        logic [7:0] k2;
        logic [7:0] k3;
        k2 = xtime(s);
        k3 = s ^ k2;
        case (mode)
            TKIP_MODE_SWAP: tkipFormat = {k3, k2};
            TKIP_MODE_AES:  tkipFormat = {8'h00, s};
            default:        tkipFormat = {k2, k3};
        endcase
    endfunction

endpackage

// File: rtl/aesSBox.sv
// -----------------------------------------------------------------------------
// aesSBox
// Purely combinational AES forward S-box byte substitution.
// Ports:
//   sBoxIn  in  8  index byte
//   sBoxOut out 8  substituted byte
// The table is held as one packed constant, row 0 in the most significant
// bits, so entry n lives at bit offset 8*(255-n) = {~n,3'b000}.
// -----------------------------------------------------------------------------
module aesSBox (
    input  logic [7:0] sBoxIn,
    output logic [7:0] sBoxOut
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sBoxOut = SBOX_TABLE[{~sBoxIn, 3'b000} +: 8];

endmodule

// File: rtl/tkip_sbox_rr_arb.sv
// -----------------------------------------------------------------------------
// tkip_sbox_rr_arb
// Round-robin arbiter for the shared S-box. The search starts one past the
// last granted channel; the pointer only moves on a real grant.
// Ports:
//   bbClk           in   1       clock
//   hardRstBbClk_n  in   1       asynchronous active-low reset
//   flush           in   1       suppresses any grant this cycle
//   req             in   NUM_CH  request levels
//   gnt             out  NUM_CH  one-hot grant (combinational)
//   gntValid        out  1       a grant is issued this cycle
//   gntIdx          out  IDX_W   index of the granted channel
// -----------------------------------------------------------------------------
module tkip_sbox_rr_arb #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              bbClk,
    input  logic              hardRstBbClk_n,
    input  logic              flush,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic              gntValid,
    output logic [IDX_W-1:0]  gntIdx
);

    localparam logic [NUM_CH-1:0] GNT_ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] lastGnt_r;
    logic [IDX_W-1:0] hitIdx_s;
    logic             hitAny_s;
    int               cand_s;

    // Rotating priority search: first requester after lastGnt_r wins.
    // Only the first hit contributes to hitIdx_s, so OR-accumulation is exact.
    always_comb begin
        hitIdx_s = '0;
        hitAny_s = 1'b0;
        cand_s   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand_s   = (int'(lastGnt_r) + i) % NUM_CH;
            hitIdx_s = hitIdx_s | ((req[cand_s[IDX_W-1:0]] && !hitAny_s) ? cand_s[IDX_W-1:0] : '0);
            hitAny_s = hitAny_s | req[cand_s[IDX_W-1:0]];
        end
    end

    // Grant outputs, gated by flush.
    always_comb begin
        if (flush || !hitAny_s) begin
            gnt      = '0;
            gntValid = 1'b0;
            gntIdx   = '0;
        end else begin
            gnt      = GNT_ONE << hitIdx_s;
            gntValid = 1'b1;
            gntIdx   = hitIdx_s;
        end
    end

    // Last-grant pointer; reset value makes channel 0 the first winner.
    always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
        if (!hardRstBbClk_n) begin
            lastGnt_r <= IDX_W'(NUM_CH - 1);
        end else if (gntValid) begin
            lastGnt_r <= gntIdx;
        end
    end

endmodule

// File: rtl/tkip_sbox_server.sv
// -----------------------------------------------------------------------------
// tkip_sbox_server
// Shared TKIP S-box lookup server. NUM_CH channels arbitrate round-robin for
// one AES S-box; each granted lookup is formatted as a TKIP word, a
// byte-swapped TKIP word or a plain AES byte and written to that channel's
// result register.
// Optional build macro: TKIP_SBOX_PIPE_EN adds a register after the S-box
// byte (latency 2 instead of 1); flush then drops both stages.
// Ports:
//   bbClk           in   1          baseband clock
//   hardRstBbClk_n  in   1          asynchronous active-low reset
//   sBoxFlush       in   1          drop in-flight lookups, block grants
//   sBoxReq         in   NUM_CH     per-channel request level
//   sBoxAddr        in   NUM_CH*8   per-channel S-box index
//   sBoxMode        in   NUM_CH*2   per-channel output format
//   sBoxGnt         out  NUM_CH     one-hot grant (combinational)
//   sBoxValid       out  NUM_CH     one-cycle update pulse per channel
//   sBoxData        out  NUM_CH*16  per-channel result registers
// -----------------------------------------------------------------------------
module tkip_sbox_server
    import tkip_sbox_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                 bbClk,
    input  logic                 hardRstBbClk_n,
    input  logic                 sBoxFlush,
    input  logic [NUM_CH-1:0]    sBoxReq,
    input  logic [NUM_CH*8-1:0]  sBoxAddr,
    input  logic [NUM_CH*2-1:0]  sBoxMode,
    output logic [NUM_CH-1:0]    sBoxGnt,
    output logic [NUM_CH-1:0]    sBoxValid,
    output logic [NUM_CH*16-1:0] sBoxData
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] gnt_s;
    logic              gntValid_s;
    logic [IDX_W-1:0]  gntIdx_s;

    logic              s1Valid_r;
    logic [7:0]        s1Addr_r;
    logic [1:0]        s1Mode_r;
    logic [IDX_W-1:0]  s1Ch_r;

    logic [7:0]        sByte_s;
    logic              wbValid_s;
    logic [7:0]        fmtByte_s;
    logic [1:0]        fmtMode_s;
    logic [IDX_W-1:0]  wbCh_s;
    logic [15:0]       wbWord_s;

    tkip_sbox_rr_arb #(.NUM_CH(NUM_CH)) uArb (
        .bbClk          (bbClk),
        .hardRstBbClk_n (hardRstBbClk_n),
        .flush          (sBoxFlush),
        .req            (sBoxReq),
        .gnt            (gnt_s),
        .gntValid       (gntValid_s),
        .gntIdx         (gntIdx_s)
    );

    assign sBoxGnt = gnt_s;

    // Stage 1: capture index, format and owner of the granted request.
    // Flush needs no explicit term here since it already blocks the grant.
    always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
        if (!hardRstBbClk_n) begin
            s1Valid_r <= 1'b0;
            s1Addr_r  <= 8'h00;
            s1Mode_r  <= 2'b00;
            s1Ch_r    <= '0;
        end else begin
            s1Valid_r <= gntValid_s;
            if (gntValid_s) begin
                s1Addr_r <= sBoxAddr[{gntIdx_s, 3'b000} +: 8];
                s1Mode_r <= sBoxMode[{gntIdx_s, 1'b0} +: 2];
                s1Ch_r   <= gntIdx_s;
            end
        end
    end

    aesSBox uSBox (
        .sBoxIn  (s1Addr_r),
        .sBoxOut (sByte_s)
    );

`ifdef TKIP_SBOX_PIPE_EN
    logic              s2Valid_r;
    logic [7:0]        s2Byte_r;
    logic [1:0]        s2Mode_r;
    logic [IDX_W-1:0]  s2Ch_r;

    // Stage 2: register the raw S-box byte; flush drops the stage-1 entry.
    always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
        if (!hardRstBbClk_n) begin
            s2Valid_r <= 1'b0;
            s2Byte_r  <= 8'h00;
            s2Mode_r  <= 2'b00;
            s2Ch_r    <= '0;
        end else begin
            s2Valid_r <= s1Valid_r && !sBoxFlush;
            s2Byte_r  <= sByte_s;
            s2Mode_r  <= s1Mode_r;
            s2Ch_r    <= s1Ch_r;
        end
    end

    assign wbValid_s = s2Valid_r && !sBoxFlush;
    assign fmtByte_s = s2Byte_r;
    assign fmtMode_s = s2Mode_r;
    assign wbCh_s    = s2Ch_r;
`else
    // Single stage: a lookup granted before a flush still completes, since
    // its write-back happens on the very edge the flush acts on.
    assign wbValid_s = s1Valid_r;
    assign fmtByte_s = sByte_s;
    assign fmtMode_s = s1Mode_r;
    assign wbCh_s    = s1Ch_r;
`endif

    assign wbWord_s = tkipFormat(fmtByte_s, fmtMode_s);

    // Per-channel result registers: only the owner's slice and pulse change.
    always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
        if (!hardRstBbClk_n) begin
            sBoxData  <= '0;
            sBoxValid <= '0;
        end else begin
            sBoxValid <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wbValid_s && (wbCh_s == IDX_W'(c))) begin
                    sBoxData[16*c +: 16] <= wbWord_s;
                    sBoxValid[c]         <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/tkip_sbox_server.md
# tkip_sbox_server

- Shared, pipelined TKIP S-box lookup server for up to NUM_CH requesting channels (phase I/II key mixing engines, per-link contexts).
- Round-robin arbitration over one AES S-box byte lookup; accepts one lookup per cycle.
- Each lookup is returned as a TKIP 16-bit word, byte-swapped TKIP word, or plain AES byte, per request.
- Each channel keeps its last result until its next one completes.

## Interface
Parameters:
- NUM_CH, 4, number of requesting channels (2..8)

Ports:
- bbClk  in  1  baseband clock
- hardRstBbClk_n  in  1  reset, asynchronous, active-low
- sBoxFlush  in  1  synchronous flush: drop in-flight lookups, block grants this cycle
- sBoxReq  in  NUM_CH  per-channel request level, held until granted
- sBoxAddr  in  NUM_CH*8  per-channel S-box index; channel c at [8c+7:8c]
- sBoxMode  in  NUM_CH*2  per-channel output format; channel c at [2c+1:2c]
- sBoxGnt  out  NUM_CH  one-hot grant (combinational from sBoxReq, pointer, sBoxFlush)
- sBoxValid  out  NUM_CH  one-cycle pulse: sBoxData slice of that channel updated
- sBoxData  out  NUM_CH*16  per-channel result register; channel c at [16c+15:16c]

## Operation
- Mode encoding:
  - 00: {k2,k3}
  - 01: {k3,k2}
  - 10: {8'h00,S}
  - 11: reserved, treated as 00
- Arithmetic, with S = AES S-box(addr):
  - k2 = {S[6:0],1'b0} ^ (S[7] ? 8'h1B : 8'h00)
  - k3 = S ^ k2
  - All operations 8-bit, no carries.
- Arbiter, round-robin:
  - Search starts at lastGnt+1 mod NUM_CH.
  - At most one sBoxGnt bit set per cycle.
  - No grant when sBoxReq==0 or sBoxFlush=1.
  - lastGnt updates only on a grant.
- Request and grant handshake:
  - On the granted edge, addr, mode and channel index are captured into stage 1.
  - Requester must drop or change its request the cycle after grant; a still-high request is a new request.
  - Withdrawing sBoxReq before grant is legal and leaves no side effect.
- Write-back:
  - On completion, the result is written only to the owning channel's sBoxData slice, with one sBoxValid pulse.
  - Other channels' slices are unchanged.
- Flush:
  - Clears all stage valid bits; no sBoxValid is raised for dropped lookups.
  - sBoxData registers and lastGnt are kept.
- Reset:
  - sBoxData = 0, sBoxValid = 0, pipeline valids = 0.
  - lastGnt = NUM_CH-1, so channel 0 has first priority.
  - Reset asserted mid-lookup discards it; no valid pulse follows deassertion.

## Timing
- Grant at edge T; result and sBoxValid registered at edge T+1 (latency 1).
- With TKIP_SBOX_PIPE_EN the latency is 2: S-box byte registered at T+1, formatted result at T+2.
- Throughput: one lookup per cycle across all channels, back-to-back, with no bubbles.
- Single active requester with continuous sBoxReq: granted every cycle; results are in order.
- Flush at cycle T with a lookup granted at T-1:
  - Without the macro, that lookup completes at edge T, since flush only blocks new grants and clears stages not yet written.
  - With the macro, the stage-1 entry is dropped.
- sBoxGnt is combinational from sBoxReq in the same cycle; there is no combinational path from sBoxAddr to any output.

## Configuration
- TKIP_SBOX_PIPE_EN defined:
  - Adds a register between the S-box byte lookup and the xtime/format logic (closes timing at high bbClk).
  - Latency is 2; flush clears both stages.
- Undefined:
  - Single stage, latency 1.
  - Format logic sits directly after the S-box lookup.

## Structure
- Package tkip_sbox_pkg holds:
  - Mode encodings (TKIP_MODE_STD=2'b00, TKIP_MODE_SWAP=2'b01, TKIP_MODE_AES=2'b10)
  - xtime function
  - NUM_CH_MAX = 8
- The existing aesSBox combinational module is instantiated once for the byte lookup.
- Sub-module tkip_sbox_rr_arb (parametrised by NUM_CH) implements the round-robin arbiter, lastGnt pointer and flush gating.
- The top level holds the pipeline stages, format mux and per-channel result registers.

## Test plan
- Reset, then ch0 requests addr 8'h00 mode 00:
  - gnt[0] in the same cycle.
  - After latency, sBoxValid[0] pulses once and sBoxData ch0 = 16'hC6A5.
  - All other slices stay 16'h0000.
- Format modes:
  - addr 8'h01 mode 01 -> 16'h84F8.
  - addr 8'h00 mode 10 -> 16'h0063.
  - addr 8'h53 mode 00 -> 16'hC12C.
  - addr 8'h53 mode 11 -> 16'hC12C.
- All four channels request continuously (NUM_CH=4):
  - Grant order is 0,1,2,3,0,...
  - One valid per cycle, each to the matching channel, with no gap.
- ch2 issues 3 back-to-back lookups (addr 00, 01, 53):
  - Three consecutive valid pulses on ch2.
  - Data sequence C6A5, F884, C12C.
- Flush:
  - Flush asserted the cycle after a grant with the macro on: no valid pulse for that lookup; ch data unchanged.
  - Flush asserted together with a pending request: no grant that cycle; request granted the next cycle.
- hardRstBbClk_n pulsed low while a lookup is in flight:
  - All sBoxData cleared and no stale valid.
  - Next grant goes to channel 0 when all channels request.
